// File: rtl/float_fixed_pkg.sv
// Shared constants and types for the float32 -> fixed-point converter.
// Fixed format is unsigned Q(INT_W).(FRAC_W) magnitude with separate sign and overflow flags.
package float_fixed_pkg;

    localparam int unsigned INT_W       = 8;
    localparam int unsigned FRAC_W      = 23;
    localparam int unsigned MANT_W      = 23;
    localparam int unsigned EXP_BIAS    = 127;
    localparam int unsigned EXP_SPECIAL = 255;
    localparam int unsigned DATA_W      = INT_W + FRAC_W;
    // Shift counter must hold FRAC_W+1, the largest right shift
    localparam int unsigned CNT_W       = $clog2(FRAC_W + 2);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StRound,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ClsZero,
        ClsSpecial,
        ClsNormal
    } class_e;

    typedef struct packed {
        logic              negative;
        logic              overflow;
        logic [INT_W-1:0]  integer_part;
        logic [FRAC_W-1:0] decimal_part;
    } fixed_result_t;

endpackage

// File: rtl/float32_classify.sv
// Combinational front end: classifies an IEEE-754 single, computes the normalisation shift
// and presents the mantissa with its hidden bit aligned as Q(INT_W).(FRAC_W) value 1.mant.
module float32_classify
    import float_fixed_pkg::*;
(
    input  logic [31:0]       in_float,
    output class_e            cls,
    output logic              overflow,
    output logic              negative,
    output logic              shift_left,
    output logic [CNT_W-1:0]  shift_amt,
    output logic [DATA_W-1:0] aligned
);

    logic [7:0] exp_field;
    logic [8:0] up_dist;
    logic [8:0] down_dist;

    assign exp_field = in_float[30:23];
    assign negative  = in_float[31];
    assign aligned   = {{(INT_W - 1){1'b0}}, 1'b1, in_float[MANT_W-1:0]};
    assign up_dist   = {1'b0, exp_field} - 9'(EXP_BIAS);
    assign down_dist = 9'(EXP_BIAS) - {1'b0, exp_field};

    always_comb begin
        cls        = ClsNormal;
        overflow   = 1'b0;
        shift_left = 1'b0;
        shift_amt  = '0;
        if (exp_field == 8'd0) begin
            cls = ClsZero;
        end else if (exp_field == 8'(EXP_SPECIAL)) begin
            cls      = ClsSpecial;
            overflow = 1'b1;
        end else if (exp_field >= 8'(EXP_BIAS)) begin
            shift_left = 1'b1;
            if (up_dist > 9'(INT_W - 1)) begin
                overflow = 1'b1;
            end else begin
                shift_amt = up_dist[CNT_W-1:0];
            end
        end else if (down_dist > 9'(FRAC_W + 1)) begin
            // Anything this small has fully drained out of the fraction field
            shift_amt = CNT_W'(FRAC_W + 1);
        end else begin
            shift_amt = down_dist[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/float32_to_fixed.sv
// IEEE-754 single to unsigned fixed-point converter with a one-bit-per-cycle normaliser.
// Define FLOAT32_TO_FIXED_ROUND_EN to round right shifts half-up via an extra ROUND cycle.
module float32_to_fixed
    import float_fixed_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_float,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INT_W-1:0]  result_integer,
    output logic [FRAC_W-1:0] result_decimal,
    output logic              result_negative,
    output logic              result_overflow
);

    class_e            cls_class;
    logic              cls_overflow;
    logic              cls_negative;
    logic              cls_left;
    logic [CNT_W-1:0]  cls_amt;
    logic [DATA_W-1:0] cls_aligned;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              left_q, left_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
`ifdef FLOAT32_TO_FIXED_ROUND_EN
    logic              guard_q, guard_d;
`endif

    fixed_result_t     res;

    float32_classify u_classify (
        .in_float   (in_float),
        .cls        (cls_class),
        .overflow   (cls_overflow),
        .negative   (cls_negative),
        .shift_left (cls_left),
        .shift_amt  (cls_amt),
        .aligned    (cls_aligned)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
`ifdef FLOAT32_TO_FIXED_ROUND_EN
        guard_d = guard_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    neg_d  = cls_negative;
                    ovf_d  = cls_overflow;
                    left_d = cls_left;
                    cnt_d  = cls_amt;
`ifdef FLOAT32_TO_FIXED_ROUND_EN
                    guard_d = 1'b0;
`endif
                    if (cls_overflow) begin
                        data_d  = '1;
                        state_d = StDone;
                    end else if (cls_class == ClsZero) begin
                        data_d  = '0;
                        state_d = StDone;
                    end else begin
                        data_d  = cls_aligned;
                        state_d = (cls_amt == '0) ? StDone : StShift;
                    end
                end
            end
            StShift: begin
                data_d = left_q ? (data_q << 1) : (data_q >> 1);
                cnt_d  = cnt_q - CNT_W'(1);
`ifdef FLOAT32_TO_FIXED_ROUND_EN
                if (!left_q) begin
                    guard_d = data_q[0];
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = left_q ? StDone : StRound;
                end
`else
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
`endif
            end
`ifdef FLOAT32_TO_FIXED_ROUND_EN
            StRound: begin
                // Right shifts leave the integer field zero, so the carry cannot overflow
                data_d  = data_q + DATA_W'(guard_q);
                state_d = StDone;
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef FLOAT32_TO_FIXED_ROUND_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guard_q <= 1'b0;
        end else begin
            guard_q <= guard_d;
        end
    end
`endif

    assign res = '{
        negative:     neg_q,
        overflow:     ovf_q,
        integer_part: data_q[DATA_W-1:FRAC_W],
        decimal_part: data_q[FRAC_W-1:0]
    };

    assign in_ready        = (state_q == StIdle);
    assign out_valid       = (state_q == StDone);
    assign result_integer  = res.integer_part;
    assign result_decimal  = res.decimal_part;
    assign result_negative = res.negative;
    assign result_overflow = res.overflow;

endmodule

// File: tb/tb_float32_to_fixed.sv
// Scoreboard bench for float32_to_fixed: directed words with hand-computed results and latency.
// Honours FLOAT32_TO_FIXED_ROUND_EN for the rounding-dependent expectations.
module tb_float32_to_fixed;

`ifdef FLOAT32_TO_FIXED_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    typedef struct {
        logic [7:0]  ip;
        logic [22:0] dp;
        logic        neg;
        logic        ovf;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_float;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  result_integer;
    logic [22:0] result_decimal;
    logic        result_negative;
    logic        result_overflow;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   acc_q[$];

    float32_to_fixed dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_float        (in_float),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .result_integer  (result_integer),
        .result_decimal  (result_decimal),
        .result_negative (result_negative),
        .result_overflow (result_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic monitor();
        exp_t        e;
        logic        pending;
        logic [32:0] held;
        int          a;
        pending = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                acc_q.delete();
                pending = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_q.push_back(cyc);
                if (out_valid) begin
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        chk("unexpected_output", 64'(out_valid), 64'd0);
                    end else if (!pending) begin
                        e = exp_q[0];
                        a = acc_q[0];
                        pending = 1'b1;
                        chk("latency", 64'(cyc - a), 64'(e.lat));
                        chk("integer", 64'(result_integer), 64'(e.ip));
                        chk("decimal", 64'(result_decimal), 64'(e.dp));
                        chk("negative", 64'(result_negative), 64'(e.neg));
                        chk("overflow", 64'(result_overflow), 64'(e.ovf));
                        held = {result_negative, result_overflow, result_integer, result_decimal};
                    end else begin
                        chk("hold_stable", 64'({result_negative, result_overflow,
                                                result_integer, result_decimal}), 64'(held));
                    end
                    if (out_ready && pending) begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        pending = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [7:0] ip, input logic [22:0] dp,
                        input logic neg, input logic ovf, input int lat);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        e.ip  = ip;
        e.dp  = dp;
        e.neg = neg;
        e.ovf = ovf;
        e.lat = lat;
        exp_q.push_back(e);
        in_float = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        acc_q.delete();
    endtask

    task automatic run(input logic [31:0] w, input logic [7:0] ip, input logic [22:0] dp,
                       input logic neg, input logic ovf, input int lat);
        send(w, ip, dp, neg, ovf, lat);
        drain();
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_float  = '0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none
        #12;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'({result_negative, result_overflow, result_integer,
                                 result_decimal}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run(32'h3FC0_0000, 8'd1,   23'h40_0000, 1'b0, 1'b0, 1);
        run(32'h4120_0000, 8'd10,  23'h00_0000, 1'b0, 1'b0, 4);
        run(32'h3E80_0000, 8'd0,   23'h20_0000, 1'b0, 1'b0, 3 + RND);
        run(32'hC380_0000, 8'hFF,  23'h7F_FFFF, 1'b1, 1'b1, 1);
        run(32'h7FC0_0000, 8'hFF,  23'h7F_FFFF, 1'b0, 1'b1, 1);
        run(32'h0000_0000, 8'd0,   23'h00_0000, 1'b0, 1'b0, 1);
        run(32'h8000_0000, 8'd0,   23'h00_0000, 1'b1, 1'b0, 1);
        run(32'h0000_0001, 8'd0,   23'h00_0000, 1'b0, 1'b0, 1);
        run(32'h7F80_0000, 8'hFF,  23'h7F_FFFF, 1'b0, 1'b1, 1);
        run(32'h437F_0000, 8'd255, 23'h00_0000, 1'b0, 1'b0, 8);
        run(32'h437F_FFFF, 8'd255, 23'h7F_FF80, 1'b0, 1'b0, 8);
        run(32'h4049_0FDB, 8'd3,   23'h12_1FB6, 1'b0, 1'b0, 2);
        run(32'hBFC0_0000, 8'd1,   23'h40_0000, 1'b1, 1'b0, 1);
        if (RND != 0) begin
            run(32'h3380_0000, 8'd0, 23'h00_0001, 1'b0, 1'b0, 26);
            run(32'h3F7F_FFFF, 8'd1, 23'h00_0000, 1'b0, 1'b0, 3);
            run(32'h3EAA_AAAB, 8'd0, 23'h2A_AAAB, 1'b0, 1'b0, 4);
        end else begin
            run(32'h3380_0000, 8'd0, 23'h00_0000, 1'b0, 1'b0, 25);
            run(32'h3F7F_FFFF, 8'd0, 23'h7F_FFFF, 1'b0, 1'b0, 2);
            run(32'h3EAA_AAAB, 8'd0, 23'h2A_AAAA, 1'b0, 1'b0, 3);
        end

        // Backpressure: result must hold and new words must be refused
        out_ready = 1'b0;
        send(32'h4120_0000, 8'd10, 23'h00_0000, 1'b0, 1'b0, 4);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            in_float = 32'h3F80_0000;
            in_valid = 1'b1;
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_out_valid_high", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_idle", 64'(in_ready), 64'd1);
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        drain();

        // Reset during SHIFT discards the word
        send(32'h3E80_0000, 8'd0, 23'h20_0000, 1'b0, 1'b0, 3 + RND);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_shift_in_ready", 64'(in_ready), 64'd1);
        chk("rst_shift_out_valid", 64'(out_valid), 64'd0);
        chk("rst_shift_result", 64'({result_integer, result_decimal}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(32'h3F80_0000, 8'd1, 23'h00_0000, 1'b0, 1'b0, 1);

        // Reset during DONE drops out_valid without a clock edge
        out_ready = 1'b0;
        send(32'hC3FF_0000, 8'hFF, 23'h7F_FFFF, 1'b1, 1'b1, 1);
        wait_valid();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_done_out_valid", 64'(out_valid), 64'd0);
        chk("rst_done_in_ready", 64'(in_ready), 64'd1);
        chk("rst_done_result", 64'({result_negative, result_overflow, result_integer,
                                    result_decimal}), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        run(32'h4049_0FDB, 8'd3, 23'h12_1FB6, 1'b0, 1'b0, 2);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/float32_to_fixed.md
Name: float32_to_fixed

Overview:
- Decodes an IEEE-754 single-precision word into the team's unsigned fixed-point integer/decimal pair (8 integer bits, 23 fraction bits), plus sign and overflow flags.
- Sits upstream of the fixed-point adder and is its input-side converter.
- Normalisation is iterative: the mantissa shifts one bit per cycle.
- Uses valid/ready handshakes on both sides.

Parameters:
- INT_W, 8: integer field width; max left shift = INT_W-1.
- FRAC_W, 23: decimal field width; max right shift before the result is zero = FRAC_W+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_float is valid
- in_ready  output  1  block can accept a word
- in_float  input  32  IEEE-754 word: sign[31], exp[30:23], mant[22:0]
- out_valid  output  1  result is valid
- out_ready  input  1  consumer takes the result
- result_integer  output  INT_W  integer part of |value|
- result_decimal  output  FRAC_W  fraction part of |value|
- result_negative  output  1  copy of the sign bit
- result_overflow  output  1  value is not representable (saturated)

Behaviour:
- Reset (async, rst=1): state IDLE, in_ready=1, out_valid=0, all result outputs 0.
- FSM states: IDLE, SHIFT, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE, in_valid=1: accept the word and classify it with e = exp-127.
  - exp==0 (zero or denormal): result 0, no overflow, go to DONE.
  - exp==255 (Inf/NaN): saturate, go to DONE.
  - e > INT_W-1: saturate, go to DONE.
  - otherwise: load datapath = {1,mant} aligned as Q(INT_W).(FRAC_W) with value 1.mant. Shift count = |e|, capped at FRAC_W+1 for right shifts.
  - count 0: go to DONE. Otherwise go to SHIFT, direction = sign of e.
- Saturate means result_integer all ones, result_decimal all ones, result_overflow=1.
- SHIFT: one-bit shift per cycle, count decrements; go to DONE when count reaches 0.
  - Right shifts truncate. Bits shifted out feed a guard bit, used only by the optional feature.
- DONE: outputs held stable while out_ready=0. On out_ready=1, return to IDLE.
- No new input is accepted in DONE, so there is no same-cycle accept/complete overlap.
- Latency: out_valid rises k+1 cycles after the accepting edge, where k = number of shifts (0..24).
- Throughput: one word per k+2 cycles with out_ready held high.
- result_negative follows the sign bit for every class, including zero and NaN (-0.0 gives negative=1, value 0).
- Reset asserted mid-SHIFT or mid-DONE: immediate return to IDLE, out_valid drops asynchronously, the in-flight word is discarded.

Optional Feature:
- Macro FLOAT32_TO_FIXED_ROUND_EN.
- Defined: on completion of a right shift, a set guard bit adds 1 LSB to the result (round half up). A carry may propagate into result_integer; 0x3F7FFFFF gives integer 1, decimal 0.
- Costs one extra cycle: a ROUND state between SHIFT and DONE, entered only for right shifts.
- Undefined: pure truncation, no ROUND state.

Decomposition:
- Package float_fixed_pkg holds:
  - constants INT_W, FRAC_W, EXP_BIAS=127, EXP_SPECIAL=255
  - state enum {IDLE, SHIFT, ROUND, DONE}
  - typedef for the fixed result struct {negative, overflow, integer, decimal}
- One natural combinational sub-module, float32_classify: takes the word, outputs class (zero/special/normal), shift amount, direction and overflow. The FSM and shifter stay in float32_to_fixed.

Test Plan:
- 0x3FC00000 (1.5) -> integer 1, decimal 0x400000, negative 0, overflow 0; out_valid exactly 1 cycle after accept.
- 0x41200000 (10.0, e=3) -> integer 10, decimal 0; out_valid 4 cycles after accept. Then 0x3E800000 (0.25, e=-2) -> integer 0, decimal 0x200000, 3 cycles.
- 0xC3800000 (-256, e=8) -> overflow 1, negative 1, integer 0xFF, decimal 0x7FFFFF. Then 0x7FC00000 (NaN) -> saturated, overflow 1. Then 0x00000000 -> all-zero result.
- 0x33800000 (2^-24) -> zero result without rounding. With FLOAT32_TO_FIXED_ROUND_EN defined -> decimal 0x000001.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid ignored. Then out_ready=1 -> IDLE next cycle.
- Assert rst during SHIFT of 0x3E800000 -> out_valid 0, in_ready 1 immediately. The next word 0x3F800000 -> integer 1, decimal 0.
